// File: rtl/sha256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 front end.
package sha256_pkg;

   localparam int BLOCK_W     = 512;
   localparam int HASH_W      = 256;
   localparam int LEN_FIELD_W = 64;
   localparam logic [7:0] PAD_BYTE = 8'h80;
   localparam int LEN_OFFSET  = 56;

   typedef enum logic [2:0] {
      S_FILL      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_CLR  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RELEASE   = 3'd4,
      S_DIGEST    = 3'd5
   } pad_state_e;

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into padded 512-bit blocks,
// sequences the compression core block by block and holds the final digest.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FILL      | accepting message bytes into the block buffer
// ISSUE     | raise core start / first_run for the buffered block
// WAIT_CLR  | one cycle where a stale core ready from the last block is ignored
// WAIT_DONE | wait for core ready, drop start, latch hash on the final block
// RELEASE   | core sees start low; choose DIGEST, length-only block or FILL
// DIGEST    | digest presented until acknowledged
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [7:0]           i_in_data,
   input  logic                 i_in_last,
   output logic                 o_core_start,
   output logic                 o_core_first_run,
   output logic [BLOCK_W-1:0]   o_core_block,
   input  logic                 i_core_ready,
   input  logic [HASH_W-1:0]    i_core_hash,
   output logic [HASH_W-1:0]    o_digest,
   output logic                 o_digest_valid,
   input  logic                 i_digest_ack,
   output logic                 o_busy
);

   pad_state_e          r_state;
   logic [5:0]          r_idx;
   logic [LEN_W-1:0]    r_count;
   logic                r_first;
   logic                r_pend80;
   logic                r_final;
   logic                r_len_pend;
   logic [BLOCK_W-1:0]  r_block;
   logic                r_core_start;
   logic                r_core_first_run;
   logic [HASH_W-1:0]   r_digest;
   logic                r_digest_valid;

   logic [5:0]          w_idx_inc;
   logic [LEN_W-1:0]    w_count_inc;
   logic [8:0]          w_lane_hi;
   logic [8:0]          w_pad_hi;

   // Length field is the byte count in bits, zero-extended to 64 bits.
   function automatic logic [LEN_FIELD_W-1:0] len_bits(input logic [LEN_W-1:0] c);
      len_bits = '0;
      len_bits[LEN_W+2:0] = {c, 3'b000};
   endfunction

   assign w_idx_inc   = r_idx + 6'd1;
   assign w_count_inc = r_count + LEN_W'(1);
   assign w_lane_hi   = 9'd511 - {r_idx, 3'b000};
   assign w_pad_hi    = 9'd511 - {w_idx_inc, 3'b000};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= S_FILL;
         r_idx            <= '0;
         r_count          <= '0;
         r_first          <= 1'b1;
         r_pend80         <= 1'b0;
         r_final          <= 1'b0;
         r_len_pend       <= 1'b0;
         r_block          <= '0;
         r_core_start     <= 1'b0;
         r_core_first_run <= 1'b0;
         r_digest         <= '0;
         r_digest_valid   <= 1'b0;
      end else begin
         unique case (r_state)
            S_FILL: begin
               if (i_in_valid) begin
                  r_block[w_lane_hi -: 8] <= i_in_data;
                  r_idx   <= w_idx_inc;
                  r_count <= w_count_inc;
                  if (i_in_last) begin
                     r_state <= S_ISSUE;
                     if (r_idx <= 6'd54) begin
                        r_block[w_pad_hi -: 8]       <= PAD_BYTE;
                        r_block[LEN_FIELD_W-1:0]     <= len_bits(w_count_inc);
                        r_final                      <= 1'b1;
                     end else if (r_idx <= 6'd62) begin
                        r_block[w_pad_hi -: 8] <= PAD_BYTE;
                        r_final                <= 1'b0;
                        r_len_pend             <= 1'b1;
                     end else begin
                        r_pend80   <= 1'b1;
                        r_final    <= 1'b0;
                        r_len_pend <= 1'b1;
                     end
                  end else if (r_idx == 6'd63) begin
                     r_state <= S_ISSUE;
                     r_final <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               r_core_start     <= 1'b1;
               r_core_first_run <= r_first;
               r_first          <= 1'b0;
               r_state          <= S_WAIT_CLR;
            end
            S_WAIT_CLR: r_state <= S_WAIT_DONE;
            S_WAIT_DONE: begin
               if (i_core_ready) begin
                  r_core_start     <= 1'b0;
                  r_core_first_run <= 1'b0;
                  if (r_final) r_digest <= i_core_hash;
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (r_final) begin
                  r_digest_valid <= 1'b1;
                  r_state        <= S_DIGEST;
               end else if (r_len_pend) begin
                  r_block <= '0;
                  if (r_pend80) r_block[BLOCK_W-1 -: 8] <= PAD_BYTE;
                  r_block[LEN_FIELD_W-1:0] <= len_bits(r_count);
                  r_final    <= 1'b1;
                  r_len_pend <= 1'b0;
                  r_state    <= S_ISSUE;
               end else begin
                  r_block <= '0;
                  r_idx   <= '0;
                  r_state <= S_FILL;
               end
            end
            S_DIGEST: begin
               // Buffer and index are cleared so the next message starts on zero fill.
               if (i_digest_ack) begin
                  r_digest_valid <= 1'b0;
                  r_count        <= '0;
                  r_first        <= 1'b1;
                  r_pend80       <= 1'b0;
                  r_final        <= 1'b0;
                  r_block        <= '0;
                  r_idx          <= '0;
                  r_state        <= S_FILL;
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign o_in_ready       = !i_rst && (r_state == S_FILL);
   assign o_core_start     = r_core_start;
   assign o_core_first_run = r_core_first_run;
   assign o_core_block     = r_block;
   assign o_digest         = r_digest;
   assign o_digest_valid   = r_digest_valid;
   assign o_busy           = !((r_state == S_FILL) && (r_idx == 6'd0) && !r_len_pend);

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front end of the SHA-256 datapath: accepts a message as a big-endian byte stream and performs FIPS 180-4 padding (0x80, zero fill, 64-bit bit length). It packs the result into 512-bit blocks and drives the compression core's `start`/`first_run`/`block_in` handshake, one block at a time. When the final block completes, it latches the core's `hash_out` and presents the digest until the consumer acknowledges it.

## Interface
- `LEN_W`, default 32: width of the internal byte counter. The 64-bit length field is {count, 3'b000}, zero-extended; the count wraps modulo 2^LEN_W.
- `clk` input 1: single clock.
- `rst` input 1: synchronous reset, active-high, shared with the compression core.
- `in_valid` input 1: message byte valid.
- `in_ready` output 1: byte accepted when `in_valid && in_ready`.
- `in_data` input 8: message byte, in stream order.
- `in_last` input 1: marks the final byte of the message. Messages are at least 1 byte.
- `core_start` output 1: registered; drives the core's `start`.
- `core_first_run` output 1: registered; 1 only while issuing a message's first block.
- `core_block` output 512: block buffer; byte i is at bits [511-8i -: 8].
- `core_ready` input 1: the core's `ready`.
- `core_hash` input 256: the core's `hash_out`.
- `digest` output 256: latched final hash.
- `digest_valid` output 1: digest held until acknowledged.
- `digest_ack` input 1: consumer acknowledgement.
- `busy` output 1: high in every state except FILL with byte index 0 and no block pending.

## Operation
- **States:** FILL, ISSUE, WAIT_CLR, WAIT_DONE, RELEASE, DIGEST. Reset enters FILL.
- **Reset values:**
  - outputs: `core_start`=0, `core_first_run`=0, `core_block`=0, `digest`=0, `digest_valid`=0.
  - internal: byte index=0, byte count=0, first flag=1, `pend80`=0, `final`=0.
  - `in_ready` is 0 while `rst` is high, otherwise `in_ready` = (state==FILL).
- **FILL:** each accepted byte is written at the current index, the index increments and the count increments.
  - Accepting byte 63 without `in_last` moves to ISSUE with `final`=0.
- **Last byte accepted at index k:**
  - k≤54: write 0x80 at k+1 and {count+1, 3'b000} into bytes 56..63 in the same cycle. Set `final`=1 and go to ISSUE.
  - 55≤k≤62: write 0x80 at k+1, go to ISSUE with `final`=0, and mark that a length-only block follows.
  - k=63: set `pend80`=1, go to ISSUE with `final`=0, and mark that a length-only block follows.
- **Length-only block:** after the previous block's RELEASE, the buffer is cleared to 0. It gets 0x80 at byte 0 if `pend80` is set, plus the length in bytes 56..63. It issues directly with `final`=1 and does not pass through FILL.
- **ISSUE** (1 cycle):
  - registers `core_start`=1 and `core_first_run`=first flag.
  - clears the first flag.
  - `core_block` is stable from this cycle until RELEASE ends.
- **WAIT_CLR** (1 cycle): `core_ready` is ignored here because it may be a stale 1 from the previous block.
- **WAIT_DONE:** held until `core_ready`=1. On that cycle:
  - drop `core_start`;
  - if `final`=1, latch `core_hash` into `digest`.
- **RELEASE** (1 cycle) lets the core see `start`=0 and return to idle. The next state is:
  - DIGEST, with `digest_valid`=1, if `final`=1;
  - the length-only ISSUE, if one is pending;
  - otherwise FILL, with buffer and index cleared.
- **DIGEST:** `in_ready`=0. When `digest_ack` is seen, clear `digest_valid`, reset count, first flag and `pend80`, then go to FILL. `digest` keeps its value until the next message's final latch.
- **Width and ordering:** byte count arithmetic is modulo 2^LEN_W. The length field is big-endian (byte 56 = MSB).
- **Reset in any state:** immediate return to reset values. `core_start` falls in the same cycle, and the partial message is discarded.

## Timing
- Byte acceptance: 1 byte/cycle in FILL, with no bubbles inside a block.
- Block issue overhead: ISSUE + WAIT_CLR + core latency (65 cycles from the core sampling `start` to `ready`=1) + RELEASE.
- `digest_valid` rises 2 cycles after `core_ready` is seen on the final block (WAIT_DONE edge, then RELEASE).
- `in_ready` first goes high one cycle after ack, or one cycle after RELEASE of a non-final block.
- `core_start` is never asserted in two consecutive blocks without an intervening low cycle.

## Structure
- Shared package `sha256_pkg`: state encoding, `BLOCK_W`=512, `HASH_W`=256, `LEN_FIELD_W`=64, `PAD_BYTE`=8'h80, `LEN_OFFSET`=56.
- This is a single module with no sub-module. Byte-lane writes are an indexed part-select on the 512-bit buffer.

## Test plan
- **"abc"** (3 bytes, `in_last` on 'c'): exactly 1 `core_start` pulse, `core_first_run`=1, and block bytes 3=0x80, 63=0x18. `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Two-block padding, 56 bytes** "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": 2 pulses, `core_first_run` 1 then 0. `digest` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **Boundary lengths:**
  - 55 bytes of 0x61 → 1 block with the length field 0x1B8.
  - 64 bytes → 2 blocks; the second has byte 0 = 0x80 and a length of 0x200.
- **Back-to-back messages:** hold `digest_ack`=0 for 20 cycles. `in_ready` stays 0 and `digest` stays stable. After ack, a second "abc" gives the same digest with `core_first_run`=1.
- **Reset mid-WAIT_DONE:** all outputs return to reset values the next cycle. A fresh "abc" then yields the correct digest.
- **Random `in_valid` gaps:** the digest still matches the reference model for a 100-byte message.
